// File: rtl/multdiv_sched.sv
// -----------------------------------------------------------------------------
// multdiv_sched
//
// Sequences the shared multi-cycle multiply/divide unit for the pipelined core.
// A MULT or DIV from execute is latched, a one-cycle start pulse is sent to the
// unit, and the pipeline is stalled until the unit answers or a timeout fires.
// The outcome retires to writeback as a one-cycle wb_valid strobe.
//
// Ports:
//   clock, reset           clock (rising edge), async active-low reset
//   op_valid, is_mult,     instruction offered by execute; accepted only when
//   is_div                 exactly one of is_mult/is_div is set
//   operand_a, operand_b   rs/rt values, latched on accept
//   dest_reg               destination register, latched on accept
//   flush                  aborts an operation in ISSUE or WAIT
//   md_ready, md_result,   unit completion, result and exception flag
//   md_exception
//   md_ctrl_mult/div       one-cycle start pulses to the unit
//   md_data_a/b            latched operands, stable for the whole operation
//   stall                  combinational pipeline freeze
//   busy                   state is not IDLE
//   wb_valid, wb_data,     writeback strobe and held result fields
//   wb_reg, wb_exception
//   dbg_state              current FSM state (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
//
// Handshake: execute offers an instruction by holding op_valid high; it is
// taken on the rising edge where op_valid & (is_mult ^ is_div) & ~flush is true
// in IDLE, and stall is high in that same cycle so execute does not advance
// past it. md_ready is a level qualifier on md_result/md_exception, sampled
// only in WAIT. wb_valid is a one-cycle strobe with no back-pressure.
// -----------------------------------------------------------------------------
module multdiv_sched #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        is_mult,
    input  logic        is_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  dest_reg,
    input  logic        flush,
    input  logic        md_ready,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_data_a,
    output logic [31:0] md_data_b,
    output logic        stall,
    output logic        busy,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_reg,
    output logic        wb_exception,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       dest_q;
    logic             accept;

    // Setting both kind bits is malformed decode and is dropped, not guessed at.
    assign accept = op_valid & (is_mult ^ is_div) & ~flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            dest_q       <= '0;
            md_ctrl_mult <= 1'b0;
            md_ctrl_div  <= 1'b0;
            md_data_a    <= '0;
            md_data_b    <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_reg       <= '0;
            wb_exception <= 1'b0;
        end else begin
            // Start pulses and the writeback strobe live for one cycle only.
            md_ctrl_mult <= 1'b0;
            md_ctrl_div  <= 1'b0;
            wb_valid     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        md_data_a    <= operand_a;
                        md_data_b    <= operand_b;
                        dest_q       <= dest_reg;
                        md_ctrl_mult <= is_mult;
                        md_ctrl_div  <= is_div;
                        cnt          <= '0;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // md_ready here belongs to an older operation; ignore it.
                    state <= flush ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (flush) begin
                        // Flush wins over a same-cycle md_ready.
                        state <= S_IDLE;
                    end else if (md_ready) begin
                        wb_data      <= md_result;
                        wb_exception <= md_exception;
                        wb_reg       <= dest_q;
                        wb_valid     <= 1'b1;
                        state        <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        // Timeout retires as an exception with a zero result.
                        wb_data      <= '0;
                        wb_exception <= 1'b1;
                        wb_reg       <= dest_q;
                        wb_valid     <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Already committing, so flush is not examined here.
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // stall drops in DONE so the instruction advances while its result retires.
    assign stall = ((state == S_IDLE) & accept) |
                   (state == S_ISSUE) |
                   ((state == S_WAIT) & ~flush);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_multdiv_sched.sv
// -----------------------------------------------------------------------------
// tb_multdiv_sched
//
// Directed bench for multdiv_sched. Inputs change 1 time unit after a rising
// edge; outputs are checked at that point (registered values) or after a short
// settle (combinational stall). Start pulses and wb_valid strobes are counted
// on falling edges so single-cycle pulses are seen exactly once.
// -----------------------------------------------------------------------------
module tb_multdiv_sched;

    logic        clock;
    logic        reset;
    logic        op_valid, is_mult, is_div;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  dest_reg;
    logic        flush, md_ready, md_exception;
    logic [31:0] md_result;
    logic        md_ctrl_mult, md_ctrl_div;
    logic [31:0] md_data_a, md_data_b;
    logic        stall, busy, wb_valid, wb_exception;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;
    logic [1:0]  dbg_state;

    int n_cmp  = 0;
    int n_mism = 0;

    int mult_pulses = 0;
    int div_pulses  = 0;
    int wbv_pulses  = 0;
    int cyc_n       = 0;
    int last_issue  = 0;
    int last_gap    = 0;

    int p_m, p_d, p_w;

    multdiv_sched #(.MAX_CYCLES(40), .CNT_W(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .op_valid     (op_valid),
        .is_mult      (is_mult),
        .is_div       (is_div),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .dest_reg     (dest_reg),
        .flush        (flush),
        .md_ready     (md_ready),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_ctrl_mult (md_ctrl_mult),
        .md_ctrl_div  (md_ctrl_div),
        .md_data_a    (md_data_a),
        .md_data_b    (md_data_b),
        .stall        (stall),
        .busy         (busy),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_reg       (wb_reg),
        .wb_exception (wb_exception),
        .dbg_state    (dbg_state)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        cyc_n++;
        if (md_ctrl_mult) mult_pulses++;
        if (md_ctrl_div)  div_pulses++;
        if (wb_valid)     wbv_pulses++;
        if (md_ctrl_mult | md_ctrl_div) begin
            last_gap   = cyc_n - last_issue;
            last_issue = cyc_n;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Offers one op in IDLE; returns positioned in WAIT cycle 1.
    task automatic issue(input logic m, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input string tag);
        op_valid  = 1'b1;
        is_mult   = m;
        is_div    = ~m;
        operand_a = a;
        operand_b = b;
        dest_reg  = rd;
        #1;
        check({tag, "_accept_stall"}, 32'(stall), 32'd1);
        cyc();
        op_valid = 1'b0;
        is_mult  = 1'b0;
        is_div   = 1'b0;
        operand_a = 32'hDEAD_BEEF;
        operand_b = 32'hCAFE_F00D;
        check({tag, "_start_pulse"}, {30'd0, md_ctrl_mult, md_ctrl_div},
              m ? 32'd2 : 32'd1);
        check({tag, "_issue_stall"}, 32'(stall), 32'd1);
        check({tag, "_data_a"}, md_data_a, a);
        check({tag, "_data_b"}, md_data_b, b);
        cyc();
    endtask

    // Advances n cycles in WAIT with md_ready low, checking the hold condition.
    task automatic wait_cycles(input int n, input string tag);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (stall !== 1'b1 || busy !== 1'b1 || wb_valid !== 1'b0 ||
                md_ctrl_mult !== 1'b0 || md_ctrl_div !== 1'b0) ok = 1'b0;
            cyc();
        end
        check({tag, "_wait_hold"}, 32'(ok), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        op_valid = 0; is_mult = 0; is_div = 0;
        operand_a = '0; operand_b = '0; dest_reg = '0;
        flush = 0; md_ready = 0; md_result = '0; md_exception = 0;

        // Reset held 4 cycles
        repeat (4) cyc();
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_stall",  32'(stall), 32'd0);
        check("rst_wbv",    32'(wb_valid), 32'd0);
        check("rst_pulses", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
        check("rst_data_a", md_data_a, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_state",  32'(dbg_state), 32'd0);
        reset = 1'b1;
        cyc();

        // MULT 7*6, ready after 17 WAIT cycles
        p_m = mult_pulses; p_w = wbv_pulses;
        issue(1'b1, 32'd7, 32'd6, 5'd9, "t1");
        wait_cycles(17, "t1");
        md_ready = 1'b1; md_result = 32'd42; md_exception = 1'b0;
        cyc();
        md_ready = 1'b0; md_result = '0;
        check("t1_wbv",      32'(wb_valid), 32'd1);
        check("t1_wb_data",  wb_data, 32'd42);
        check("t1_wb_reg",   32'(wb_reg), 32'd9);
        check("t1_wb_exc",   32'(wb_exception), 32'd0);
        check("t1_done_stall", 32'(stall), 32'd0);
        check("t1_done_busy",  32'(busy), 32'd1);
        cyc();
        check("t1_idle_wbv",  32'(wb_valid), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_data_hold", wb_data, 32'd42);
        check("t1_mult_count", 32'(mult_pulses - p_m), 32'd1);
        check("t1_wbv_count",  32'(wbv_pulses - p_w), 32'd1);

        // DIV 100/0 with exception
        p_d = div_pulses; p_w = wbv_pulses;
        issue(1'b0, 32'd100, 32'd0, 5'd17, "t2");
        wait_cycles(3, "t2");
        md_ready = 1'b1; md_result = 32'hFFFF_FFFF; md_exception = 1'b1;
        cyc();
        md_ready = 1'b0; md_result = '0; md_exception = 1'b0;
        check("t2_wbv",     32'(wb_valid), 32'd1);
        check("t2_wb_exc",  32'(wb_exception), 32'd1);
        check("t2_wb_data", wb_data, 32'hFFFF_FFFF);
        check("t2_wb_reg",  32'(wb_reg), 32'd17);
        cyc();
        check("t2_div_count", 32'(div_pulses - p_d), 32'd1);
        check("t2_wbv_count", 32'(wbv_pulses - p_w), 32'd1);

        // Timeout: DONE after exactly 40 WAIT cycles
        p_w = wbv_pulses;
        issue(1'b1, 32'd2, 32'd3, 5'd4, "t3");
        wait_cycles(39, "t3");
        check("t3_wait40_busy", 32'(busy), 32'd1);
        check("t3_wait40_wbv",  32'(wb_valid), 32'd0);
        cyc();
        check("t3_wbv",     32'(wb_valid), 32'd1);
        check("t3_wb_data", wb_data, 32'd0);
        check("t3_wb_exc",  32'(wb_exception), 32'd1);
        check("t3_wb_reg",  32'(wb_reg), 32'd4);
        cyc();
        check("t3_wbv_count", 32'(wbv_pulses - p_w), 32'd1);

        // Flush on WAIT cycle 5, late md_ready on cycle 6
        p_w = wbv_pulses;
        issue(1'b1, 32'd5, 32'd5, 5'd6, "t4");
        wait_cycles(4, "t4");
        flush = 1'b1;
        #1;
        check("t4_flush_stall", 32'(stall), 32'd0);
        check("t4_flush_busy",  32'(busy), 32'd1);
        cyc();
        flush = 1'b0;
        md_ready = 1'b1; md_result = 32'd25;
        #1;
        check("t4_after_busy",  32'(busy), 32'd0);
        check("t4_after_stall", 32'(stall), 32'd0);
        cyc();
        md_ready = 1'b0; md_result = '0;
        cyc();
        check("t4_no_wbv",    32'(wbv_pulses - p_w), 32'd0);
        check("t4_exc_hold",  32'(wb_exception), 32'd1);
        check("t4_reg_hold",  32'(wb_reg), 32'd4);

        // Reset asserted on WAIT cycle 3
        issue(1'b1, 32'd11, 32'd13, 5'd7, "t5");
        wait_cycles(2, "t5");
        #1;
        reset = 1'b0;
        #1;
        check("t5_rst_busy",   32'(busy), 32'd0);
        check("t5_rst_stall",  32'(stall), 32'd0);
        check("t5_rst_data_a", md_data_a, 32'd0);
        check("t5_rst_data_b", md_data_b, 32'd0);
        check("t5_rst_exc",    32'(wb_exception), 32'd0);
        check("t5_rst_reg",    32'(wb_reg), 32'd0);
        check("t5_rst_state",  32'(dbg_state), 32'd0);
        cyc();
        cyc();
        reset = 1'b1;
        p_m = mult_pulses; p_d = div_pulses; p_w = wbv_pulses;
        md_ready = 1'b1; md_result = 32'd143;
        cyc();
        md_ready = 1'b0; md_result = '0;
        cyc();
        cyc();
        check("t5_no_stale_start", 32'(mult_pulses + div_pulses - p_m - p_d), 32'd0);
        check("t5_no_stale_wbv",   32'(wbv_pulses - p_w), 32'd0);
        issue(1'b0, 32'd9, 32'd3, 5'd8, "t5div");
        wait_cycles(5, "t5div");
        md_ready = 1'b1; md_result = 32'd3;
        cyc();
        md_ready = 1'b0; md_result = '0;
        check("t5_div_wbv",  32'(wb_valid), 32'd1);
        check("t5_div_data", wb_data, 32'd3);
        check("t5_div_reg",  32'(wb_reg), 32'd8);
        check("t5_div_exc",  32'(wb_exception), 32'd0);
        cyc();

        // Malformed and non-multdiv instructions are ignored
        p_m = mult_pulses; p_d = div_pulses;
        op_valid = 1'b1; is_mult = 1'b1; is_div = 1'b1;
        operand_a = 32'h1111_1111; operand_b = 32'h2222_2222; dest_reg = 5'd30;
        #1;
        check("t6_both_stall", 32'(stall), 32'd0);
        cyc();
        check("t6_both_busy", 32'(busy), 32'd0);
        is_mult = 1'b0; is_div = 1'b0;
        #1;
        check("t6_none_stall", 32'(stall), 32'd0);
        cyc();
        op_valid = 1'b0;
        check("t6_none_busy",   32'(busy), 32'd0);
        check("t6_no_start",    32'(mult_pulses + div_pulses - p_m - p_d), 32'd0);
        check("t6_data_a_hold", md_data_a, 32'd9);
        check("t6_data_b_hold", md_data_b, 32'd3);

        // Back-to-back MULT 3*5 then DIV 20/4
        issue(1'b1, 32'd3, 32'd5, 5'd10, "t7m");
        md_ready = 1'b1; md_result = 32'd15;
        cyc();
        md_ready = 1'b0; md_result = '0;
        check("t7_mult_wbv",  32'(wb_valid), 32'd1);
        check("t7_mult_data", wb_data, 32'd15);
        check("t7_mult_reg",  32'(wb_reg), 32'd10);
        cyc();
        issue(1'b0, 32'd20, 32'd4, 5'd11, "t7d");
        check("t7_issue_gap", 32'(last_gap), 32'd4);
        md_ready = 1'b1; md_result = 32'd5;
        cyc();
        md_ready = 1'b0; md_result = '0;
        check("t7_div_wbv",  32'(wb_valid), 32'd1);
        check("t7_div_data", wb_data, 32'd5);
        check("t7_div_reg",  32'(wb_reg), 32'd11);
        cyc();
        check("t7_final_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule

// File: doc/multdiv_sched.md
Name: multdiv_sched

Overview:
- Sequences the shared multi-cycle multiply/divide unit for the 5-stage pipelined processor core.
- Accepts a MULT or DIV instruction from the execute stage and latches its operands and destination register.
- Issues a one-cycle start pulse to the multdiv unit and holds the pipeline stalled until the unit reports ready or a timeout expires.
- Delivers the result, exception flag and destination register to writeback as a one-cycle valid pulse; honours pipeline flushes.

Parameters:
- MAX_CYCLES, 40, WAIT cycles allowed before timeout. Legal range 2..255.
- CNT_W, 8, width of the cycle counter. Must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- op_valid  in  1  execute stage presents an instruction this cycle.
- is_mult  in  1  instruction is MULT.
- is_div  in  1  instruction is DIV.
- operand_a  in  32  rs value.
- operand_b  in  32  rt value.
- dest_reg  in  5  destination register number.
- flush  in  1  pipeline flush (branch/jump taken); aborts the current operation.
- md_ready  in  1  multdiv unit result valid.
- md_result  in  32  multdiv unit result.
- md_exception  in  1  multdiv unit exception (overflow / divide by zero).
- md_ctrl_mult  out  1  one-cycle MULT start pulse.
- md_ctrl_div  out  1  one-cycle DIV start pulse.
- md_data_a  out  32  latched operand A, held stable for the whole operation.
- md_data_b  out  32  latched operand B, held stable for the whole operation.
- stall  out  1  freeze PC, F/D, D/X (combinational).
- busy  out  1  state is not IDLE.
- wb_valid  out  1  one-cycle result strobe.
- wb_data  out  32  result.
- wb_reg  out  5  destination register.
- wb_exception  out  1  exception or timeout.

Behaviour:
- Reset: all registered outputs 0; state = IDLE; counter = 0. The reset is asynchronous and overrides every other input, including mid-operation. After release, no stale pulse or wb_valid is produced.
- States and transitions:
  - IDLE: accept = op_valid & (is_mult ^ is_div) & ~flush. On the accept edge: latch operands, dest_reg and op kind; set md_ctrl_mult or md_ctrl_div; clear the counter; go to ISSUE.
  - IDLE, ignored cases: if is_mult and is_div are both high, the instruction is not accepted and stall stays 0. Non-multdiv instructions are likewise ignored.
  - ISSUE: exactly one start pulse is high this cycle. md_ready is ignored as stale. Next state is WAIT and the start pulse clears.
  - WAIT: the counter increments every edge.
    - If md_ready: capture wb_data = md_result and wb_exception = md_exception; go to DONE.
    - Else if counter == MAX_CYCLES-1: wb_data = 0, wb_exception = 1; go to DONE.
  - DONE: wb_valid = 1 for exactly this cycle, with wb_reg = latched dest_reg. Next state is IDLE. wb_data, wb_reg and wb_exception hold until the next DONE.
- Flush: when flush = 1 in ISSUE or WAIT, the next state is IDLE. The start pulse clears and there is no wb_valid. A late md_ready is ignored.
  - Flush in DONE has no effect; the pulse still occurs because the instruction is already committing.
  - Flush has priority over md_ready in the same cycle.
- stall = (IDLE & accept) | ISSUE | (WAIT & ~flush). stall is 0 in DONE so the instruction advances while the result retires.
- busy = (state != IDLE).
- Back-to-back operations: a new op is accepted in the cycle after DONE, earliest. Minimum issue-to-issue spacing is 4 cycles.
- Latency: accept at edge E0, ready sampled at edge En, wb_valid high during cycle En..En+1.
- md_data_a/md_data_b change only on an accept edge.

Test Plan:
- Reset held 4 cycles, then MULT a=7 b=6, md_ready after 17 WAIT cycles with md_result=42 -> exactly one md_ctrl_mult pulse, stall high until DONE, wb_valid single pulse, wb_data=42, wb_reg=dest, wb_exception=0.
- DIV a=100 b=0, md_ready with md_exception=1 -> md_ctrl_div pulse, wb_exception=1, wb_valid once.
- MULT, md_ready never asserts, MAX_CYCLES=40 -> DONE after 40 WAIT cycles, wb_data=0, wb_exception=1.
- MULT, flush on WAIT cycle 5, md_ready on cycle 6 -> no wb_valid, stall drops in the flush cycle, busy=0 next cycle.
- reset driven low on WAIT cycle 3 -> all outputs 0 immediately; no pulse after release; a subsequent DIV 9/3 returns 3.
- is_mult=is_div=1 -> not accepted, stall=0; then back-to-back MULT 3*5 and DIV 20/4 -> wb_data 15 then 5, issue spacing >= 4 cycles.
